// File: rtl/demux_l1_sched.sv
// demux_l1_sched: sequencing controller for the first RX demux layer.
//
// Two 8-bit lanes, each feeding a 1x2 demux (lane 0 -> out0/out1, lane 1 -> out2/out3).
// The block aligns both lanes before routing starts. It then alternates each lane's
// selector on every valid beat. When any downstream FIFO reports almost-full, it raises
// a registered pause towards upstream.
//
// Ports:
//   clk_f          clock, all state updates on its rising edge
//   reset          asynchronous active-low reset
//   enable         scheduler enable
//   valid_in0/1    lane word valids
//   almost_full    downstream almost-full flags, bit n = output n
//   sel0/sel1      lane demux selectors
//   lane_en0/1     lane valid qualifiers, high in ACTIVE and HOLD
//   pause          backpressure to upstream
//   state          IDLE=0, ALIGN=1, ACTIVE=2, HOLD=3
//   word_cnt0..3   words routed to each output
//   drop_cnt       words discarded while aligning
//
// Build option: define DEMUX_SCHED_CNT_EN to build the word and drop counters.
// Without it, the counter outputs are tied to zero.

module demux_l1_sched #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned HOLD_CYC = 2
) (
  input  logic             clk_f,
  input  logic             reset,
  input  logic             enable,
  input  logic             valid_in0,
  input  logic             valid_in1,
  input  logic [3:0]       almost_full,
  output logic             sel0,
  output logic             sel1,
  output logic             lane_en0,
  output logic             lane_en1,
  output logic             pause,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] word_cnt0,
  output logic [CNT_W-1:0] word_cnt1,
  output logic [CNT_W-1:0] word_cnt2,
  output logic [CNT_W-1:0] word_cnt3,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [3:0] HoldCyc = 4'(HOLD_CYC);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAlign  = 2'd1,
    StActive = 2'd2,
    StHold   = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic       sel0_q, sel0_d;
  logic       sel1_q, sel1_d;
  logic       pause_q, pause_d;
  logic [3:0] hold_q, hold_d;
  // Per-output increment strobes (bit n = output n) and the align drop strobe.
  logic [3:0] route_inc;
  logic       drop_inc;

  always_comb begin
    state_d   = state_q;
    sel0_d    = sel0_q;
    sel1_d    = sel1_q;
    hold_d    = hold_q;
    route_inc = '0;
    drop_inc  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StAlign;
      end
      StAlign: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (valid_in0 && valid_in1) begin
          // Aligning beat itself is not routed; routing starts next cycle on sel=0.
          state_d = StActive;
          sel0_d  = 1'b0;
          sel1_d  = 1'b0;
        end else if (valid_in0 ^ valid_in1) begin
          drop_inc = 1'b1;
        end
      end
      StActive, StHold: begin
        if (!enable) begin
          state_d = StIdle;
          sel0_d  = 1'b0;
          sel1_d  = 1'b0;
          hold_d  = '0;
        end else begin
          // Routing keeps going in HOLD: upstream has a one-cycle skid.
          if (valid_in0) begin
            route_inc[{1'b0, sel0_q}] = 1'b1;
            sel0_d = ~sel0_q;
          end
          if (valid_in1) begin
            route_inc[{1'b1, sel1_q}] = 1'b1;
            sel1_d = ~sel1_q;
          end
          if (state_q == StActive) begin
            if (|almost_full) begin
              state_d = StHold;
              hold_d  = '0;
            end
          end else if (hold_q == HoldCyc) begin
            // Leave one cycle after the HOLD_CYC-th consecutive clean cycle was counted.
            state_d = StActive;
            hold_d  = '0;
          end else if (|almost_full) begin
            hold_d = '0;
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    pause_d = (state_d == StHold);
  end

  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      sel0_q  <= 1'b0;
      sel1_q  <= 1'b0;
      pause_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      sel0_q  <= sel0_d;
      sel1_q  <= sel1_d;
      pause_q <= pause_d;
      hold_q  <= hold_d;
    end
  end

  assign state    = state_q;
  assign sel0     = sel0_q;
  assign sel1     = sel1_q;
  assign pause    = pause_q;
  assign lane_en0 = (state_q == StActive) || (state_q == StHold);
  assign lane_en1 = lane_en0;

`ifdef DEMUX_SCHED_CNT_EN
  logic [CNT_W-1:0] word_cnt_q [4];
  logic [CNT_W-1:0] drop_cnt_q;

  // Counters wrap freely.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) word_cnt_q[i] <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (route_inc[i]) word_cnt_q[i] <= word_cnt_q[i] + CNT_W'(1);
      end
      if (drop_inc) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign word_cnt0 = word_cnt_q[0];
  assign word_cnt1 = word_cnt_q[1];
  assign word_cnt2 = word_cnt_q[2];
  assign word_cnt3 = word_cnt_q[3];
  assign drop_cnt  = drop_cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^{route_inc, drop_inc};

  assign word_cnt0 = '0;
  assign word_cnt1 = '0;
  assign word_cnt2 = '0;
  assign word_cnt3 = '0;
  assign drop_cnt  = '0;
`endif

endmodule

// File: doc/demux_l1_sched.md
Name: demux_l1_sched

Overview:
- Sequencing controller for the first RX demux layer: two 8-bit input lanes, each split by a 1x2 demux into two outputs (lane 0 -> out0/out1, lane 1 -> out2/out3).
- Generates per-lane selectors and lane enables (gating the demux input valids).
- Aligns both lanes before routing starts and applies backpressure upstream when downstream FIFOs approach full.
- Sits between the RX lane receivers and the L1 demux, in the clk_f domain.

Parameters:
- CNT_W, 8, width of the per-output word counters and the drop counter.
- HOLD_CYC, 2, consecutive cycles with almost_full all-zero required to leave HOLD (legal range 1..15).

Ports:
- clk_f  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  scheduler enable.
- valid_in0  input  1  lane 0 word valid (same signal feeding the demux validEntrada0).
- valid_in1  input  1  lane 1 word valid.
- almost_full  input  4  downstream FIFO almost-full flags, bit n = output n.
- sel0  output  1  lane 0 demux selector (0 -> out0, 1 -> out1).
- sel1  output  1  lane 1 demux selector (0 -> out2, 1 -> out3).
- lane_en0  output  1  qualifies valid_in0 into the demux.
- lane_en1  output  1  qualifies valid_in1 into the demux.
- pause  output  1  registered backpressure to upstream.
- state  output  2  IDLE=0, ALIGN=1, ACTIVE=2, HOLD=3.
- word_cnt0..word_cnt3  output  CNT_W each  words routed to outputs 0..3.
- drop_cnt  output  CNT_W  words discarded during ALIGN.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; sel0=sel1=0; pause=0; hold counter=0; all counters=0.
  - Release is synchronous: the first transition is evaluated at the first clk_f edge with reset=1.
- All outputs are registered or decoded directly from registers; no input-to-output combinational path.
- lane_en0 = lane_en1 = 1 iff state is ACTIVE or HOLD.
- IDLE -> ALIGN when enable=1.
- ALIGN:
  - Cycle with valid_in0 && valid_in1 -> ACTIVE next edge. That beat is not routed; the demux sees the first routed word on the following cycle, with sel=0.
  - Cycle with exactly one valid: that word is dropped; drop_cnt += 1. If both valids are high, ALIGN exits and nothing is dropped.
- ACTIVE/HOLD routing, independently per lane:
  - Beat with valid_inN=1 is routed per the current selN. selN toggles at that edge.
  - word_cnt of the selected output increments at the same edge.
  - valid_inN=0 leaves selN and the counters unchanged.
- ACTIVE -> HOLD when any almost_full bit=1. pause=1 from that edge onward.
- HOLD:
  - Routing continues, because upstream has a 1-cycle skid.
  - Hold counter increments each cycle almost_full==0 and clears on any set bit.
  - When the count reaches HOLD_CYC -> ACTIVE; pause=0 and hold counter=0 at that edge.
- enable=0 in ALIGN/ACTIVE/HOLD -> IDLE next edge. sel0/sel1/pause/hold counter clear; counters hold their values. This takes priority over all other transitions in the same cycle.
- Counters wrap modulo 2^CNT_W; there is no saturation.
- Reset mid-operation: immediate return to reset values regardless of state.

Optional Feature:
- DEMUX_SCHED_CNT_EN defined: word_cnt0..3 and drop_cnt are implemented as described.
- Undefined: counter registers are not built; word_cnt0..3 and drop_cnt are tied to 0. State machine, selectors and pause behaviour are identical in both builds.

Test Plan:
- Reset then enable=1, valid_in0=1 only for 3 cycles, then both valids 1 -> state 1 during the single-lane cycles; drop_cnt=3; state=2 after the aligning beat; sel0=sel1=0, lane_en=1.
- ACTIVE, 6 consecutive beats on both lanes -> sel0/sel1 toggle 0,1,0,1,0,1; word_cnt0..3 = 3,3,3,3.
- ACTIVE, valid_in0 pattern 1,0,1 with valid_in1=0 -> sel0=0 then 1 then 1 then 0; word_cnt0=1, word_cnt1=1; sel1 stays 0.
- almost_full=4'b0100 for 1 cycle, then 0, HOLD_CYC=2 -> state=3 and pause=1 for exactly 3 cycles; routing and counts continue during HOLD; return to state=2 with pause=0.
- In HOLD, almost_full flickers 0,1,0,0 -> hold counter restarts; ACTIVE only after the final two zero cycles.
- Assert reset low mid-ACTIVE with nonzero counts -> all outputs 0 and state=0 asynchronously. Separately, enable=0 in ACTIVE -> state=0, sel=0, counters retained. With the macro undefined, all counts read 0 throughout.
